// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: load encodings and the packed inter-stage buses.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;

  // EXE -> MEM payload, 76 bits
  typedef struct packed {
    logic [2:0]        load_type;
    logic [1:0]        addr_low;
    logic              res_from_mem;
    logic              gr_we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc;
  } es_to_ms_t;

  // MEM -> WB payload, 70 bits
  typedef struct packed {
    logic              gr_we;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] final_result;
    logic [DATA_W-1:0] pc;
  } ms_to_ws_t;

  // MEM -> ID bypass/stall info, 39 bits
  typedef struct packed {
    logic              fwd_we;
    logic [REG_W-1:0]  dest;
    logic              load_pending;
    logic [DATA_W-1:0] final_result;
  } ms_fwd_t;

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and bus signals around the MEM stage (EXE in, WB out, ID bypass, data SRAM response).
// Latency: n/a (wiring only).
// Backpressure: ws_allowin from WB, ms_allowin towards EXE.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic        es_to_ms_valid;
  es_to_ms_t   es_to_ms_bus;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  ms_to_ws_t   ms_to_ws_bus;
  logic        ws_allowin;
  ms_fwd_t     ms_fwd_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  // master: the MEM stage itself
  modport master (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

  // slave: surrounding pipeline (EXE, WB, ID, data SRAM)
  modport slave (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: load_type, addr_low (byte offset), word (raw SRAM word) -> data (register value).
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection uses only addr_low[1]; the low bit is don't-care.
  assign byte_sel = 8'(word >> {addr_low, 3'b000});
  assign half_sel = 16'(word >> {addr_low[1], 4'b0000});

  always_comb begin
    data = word;
    case (load_type)
      LOAD_LB:  data = ext8(byte_sel, 1'b1);
      LOAD_LBU: data = ext8(byte_sel, 1'b0);
      LOAD_LH:  data = ext16(half_sel, 1'b1);
      LOAD_LHU: data = ext16(half_sel, 1'b0);
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE result, waits for load data, aligns it, hands off to WB.
// Latency: 1 cycle for non-loads; loads stay until data_sram_data_ok (min 1 cycle).
// Backpressure: holds while ws_allowin=0; a one-entry buffer keeps load data that arrives during a WB stall.
// Ports: clk, reset (async, active-high), ms_if (mem_stage_if.master: EXE in, WB out, ID fwd, SRAM resp).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.master ms_if
);

  logic        ms_valid;
  es_to_ms_t   es_to_ms_bus_r;
  logic        rbuf_valid;
  logic [31:0] rbuf_data;

  logic        ms_ready_go;
  logic        ms_allowin;
  logic        ms_to_ws_valid;
  logic        ms_leave;
  logic        rbuf_capture;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_ready_go    = !es_to_ms_bus_r.res_from_mem || rbuf_valid || ms_if.data_sram_data_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ms_if.ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_leave       = ms_to_ws_valid && ms_if.ws_allowin;

  // Only capture when WB is stalled; if WB accepts this cycle the word bypasses straight through.
  // A response while idle, for a non-load, or with the buffer already full is dropped.
  assign rbuf_capture = ms_if.data_sram_data_ok && ms_valid && es_to_ms_bus_r.res_from_mem &&
                        !rbuf_valid && !ms_if.ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      es_to_ms_bus_r <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= ms_if.es_to_ms_valid;
      end
      if (ms_if.es_to_ms_valid && ms_allowin) begin
        es_to_ms_bus_r <= ms_if.es_to_ms_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf_valid <= 1'b0;
      rbuf_data  <= '0;
    end else if (ms_leave) begin
      rbuf_valid <= 1'b0;
    end else if (rbuf_capture) begin
      rbuf_valid <= 1'b1;
      rbuf_data  <= ms_if.data_sram_rdata;
    end
  end

  assign load_word = rbuf_valid ? rbuf_data : ms_if.data_sram_rdata;

  mem_stage_load_align u_load_align (
    .load_type (es_to_ms_bus_r.load_type),
    .addr_low  (es_to_ms_bus_r.addr_low),
    .word      (load_word),
    .data      (load_data)
  );

  assign final_result = es_to_ms_bus_r.res_from_mem ? load_data : es_to_ms_bus_r.alu_result;

  assign ms_if.ms_allowin     = ms_allowin;
  assign ms_if.ms_to_ws_valid = ms_to_ws_valid;

  assign ms_if.ms_to_ws_bus.gr_we        = es_to_ms_bus_r.gr_we;
  assign ms_if.ms_to_ws_bus.dest         = es_to_ms_bus_r.dest;
  assign ms_if.ms_to_ws_bus.final_result = final_result;
  assign ms_if.ms_to_ws_bus.pc           = es_to_ms_bus_r.pc;

  // While a load is still waiting, ID must stall rather than take final_result.
  assign ms_if.ms_fwd_bus.fwd_we       = ms_valid && es_to_ms_bus_r.gr_we;
  assign ms_if.ms_fwd_bus.dest         = es_to_ms_bus_r.dest;
  assign ms_if.ms_fwd_bus.load_pending = ms_valid && es_to_ms_bus_r.res_from_mem && !ms_ready_go;
  assign ms_if.ms_fwd_bus.final_result = final_result;

endmodule
